// File: rtl/sense_sync_rx.sv
// Terminates a 4-phase bundled-data push channel into clk, buffering bits in a FWFT FIFO.
// Optional statistics counters are enabled by defining SENSE_RX_STATS_EN.
module sense_sync_rx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
`ifdef SENSE_RX_STATS_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push_0r,
  output logic                     push_0a,
  input  logic                     push_0d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_data,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef SENSE_RX_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         stat_ones,
  output logic [CNT_W-1:0]         stat_total,
  output logic [CNT_W-1:0]         stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPT, WAITLO} state_t;

  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEPTH-1:0]       mem_q, mem_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            level_q, level_d;
  logic                   req_s, full, wr_en, pop;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], push_0r};
  assign req_s  = sync_q[SYNC_STAGES-1];
  // Full is judged on the registered level, so a same-cycle pop defers a write.
  assign full   = (level_q == FULL_LVL);
  assign pop    = (level_q != '0) && out_ready;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (req_s) state_d = CAPT;
      end
      CAPT: begin
        if (!full) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = WAITLO;
        end
      end
      WAITLO: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_0d;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      sync_q   <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      sync_q   <= sync_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign push_0a    = ack_q;
  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

`ifdef SENSE_RX_STATS_EN
  logic [CNT_W-1:0] ones_q, ones_d, total_q, total_d, stall_q, stall_d;
  logic             stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  assign stall = (state_q == CAPT) && full;

  always_comb begin
    ones_d  = sat_inc(ones_q, wr_en && push_0d);
    total_d = sat_inc(total_q, wr_en);
    stall_d = sat_inc(stall_q, stall);
    if (stat_clr) begin
      ones_d  = '0;
      total_d = '0;
      stall_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ones_q  <= '0;
      total_q <= '0;
      stall_q <= '0;
    end else begin
      ones_q  <= ones_d;
      total_q <= total_d;
      stall_q <= stall_d;
    end
  end

  assign stat_ones  = ones_q;
  assign stat_total = total_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_sense_sync_rx.sv
// Bench for sense_sync_rx: queue-based reference model plus directed handshake scenarios.
module tb_sense_sync_rx;
  localparam int DEPTH = 4;
  localparam int S     = 2;

  logic       clk = 1'b0;
  logic       nreset, push_0r, push_0d, out_ready, stat_clr;
  logic       push_0a, out_valid, out_data;
  logic [2:0] fifo_level;
`ifdef SENSE_RX_STATS_EN
  logic [15:0] stat_ones, stat_total, stat_stall;
`endif

  sense_sync_rx #(.DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk(clk), .nreset(nreset), .push_0r(push_0r), .push_0a(push_0a), .push_0d(push_0d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .fifo_level(fifo_level)
`ifdef SENSE_RX_STATS_EN
    , .stat_clr(stat_clr), .stat_ones(stat_ones), .stat_total(stat_total), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: req_s is push_0r seen through S flops; phase 0 = waiting for
  // a request, 1 = request seen and awaiting FIFO space, 2 = acknowledged.
  bit mq[$];
  bit line[$];
  bit m_rs, m_ack, m_wr, m_pop;
  int m_phase;
  int m_ones, m_total, m_stall;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mq.delete(); line.delete();
      m_rs = 0; m_ack = 0; m_phase = 0;
      m_ones = 0; m_total = 0; m_stall = 0;
    end else begin
      m_wr  = (m_phase == 1) && (mq.size() < DEPTH);
      m_pop = (mq.size() != 0) && out_ready;
      if (stat_clr) begin
        m_ones = 0; m_total = 0; m_stall = 0;
      end else begin
        if (m_wr) begin m_total++; if (push_0d) m_ones++; end
        if (m_phase == 1 && mq.size() == DEPTH) m_stall++;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_wr) mq.push_back(push_0d);
      if (m_phase == 0 && m_rs) m_phase = 1;
      else if (m_phase == 1 && m_wr) m_phase = 2;
      else if (m_phase == 2 && !m_rs) m_phase = 0;
      m_ack = (m_phase == 2);
      line.push_back(push_0r);
      if (line.size() > S) void'(line.pop_front());
      m_rs = (line.size() == S) ? line[0] : 1'b0;
    end
  end

  int max_lvl = 0;
  always @(negedge clk) begin
    chk("ack", push_0a, m_ack);
    chk("valid", out_valid, mq.size() != 0);
    chk("level", fifo_level, mq.size());
    if (mq.size() != 0) chk("data", out_data, mq[0]);
`ifdef SENSE_RX_STATS_EN
    chk("stat_ones", stat_ones, m_ones);
    chk("stat_total", stat_total, m_total);
    chk("stat_stall", stat_stall, m_stall);
`endif
    if (fifo_level > max_lvl) max_lvl = fifo_level;
  end

  bit got[$];
  always @(posedge clk)
    if (nreset && out_valid && out_ready) got.push_back(out_data);

  int fall_lat;

  // One request; out_ready pulses only for edge pop_at, stat_clr only for edge clr_at.
  task automatic push(input bit d, input int pop_at, input int clr_at, input bit drop, output int lat);
    @(negedge clk);
    push_0d = d; push_0r = 1'b1; lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (pop_at != 0) out_ready = (pop_at == n);
      stat_clr = (clr_at == n);
      @(negedge clk);
      if (push_0a) begin lat = n; break; end
    end
    if (pop_at != 0) out_ready = 1'b0;
    stat_clr = 1'b0;
    if (lat == 0) chk("ack_rise_timeout", 0, 1);
    if (drop) begin
      push_0r = 1'b0; fall_lat = 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (!push_0a) begin fall_lat = n; break; end
      end
      if (fall_lat == 0) chk("ack_fall_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic chk_seq(input string nm, input bit exp[]);
    chk({nm, "_len"}, got.size(), exp.size());
    foreach (exp[i]) if (i < got.size()) chk($sformatf("%s_%0d", nm, i), got[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int lat;
  initial begin
    nreset = 1'b0; push_0r = 1'b1; push_0d = 1'b1; out_ready = 1'b0; stat_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", push_0a, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_data", out_data, 0);

    // Request already high at release counts as a new item.
    nreset = 1'b1; lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (push_0a) begin lat = n; break; end
    end
    chk("rise_latency", lat, 4);
    chk("first_level", fifo_level, 1);
    chk("first_data", out_data, 1);
    push_0r = 1'b0; lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!push_0a) begin lat = n; break; end
    end
    chk("fall_latency", lat, 3);
    drain();

    // Streaming with a consumer that is always ready.
    got.delete(); max_lvl = 0; out_ready = 1'b1;
    begin
      bit pat[] = '{1, 0, 1, 1, 0, 0, 1, 0};
      foreach (pat[i]) push(pat[i], 0, 0, 1, lat);
      repeat (3) @(negedge clk);
      chk_seq("stream", pat);
    end
    chk("stream_max_level_le1", int'(max_lvl <= 1), 1);
    out_ready = 1'b0;

    // Back-pressure: fifth request waits until one pop frees a slot.
    got.delete();
    push(1, 0, 0, 1, lat); push(0, 0, 0, 1, lat);
    push(1, 0, 0, 1, lat); push(1, 0, 0, 1, lat);
    chk("bp_level_full", fifo_level, 4);
    push(0, 10, 0, 1, lat);
    chk("bp_ack_after_pop", lat, 11);
    chk("bp_level_after", fifo_level, 4);
    drain();
    chk_seq("bp", '{1, 0, 1, 1, 0});

    // Pop coincides with the write edge at level 2.
    got.delete();
    push(1, 0, 0, 1, lat); push(0, 0, 0, 1, lat);
    push(1, 4, 0, 1, lat);
    chk("simul_lat", lat, 4);
    chk("simul_level", fifo_level, 2);
    drain();
    chk_seq("simul", '{1, 0, 1});

    // Async reset while holding ack with three entries queued.
    got.delete();
    push(1, 0, 0, 1, lat); push(1, 0, 0, 1, lat);
    push(0, 0, 0, 0, lat);
    chk("mid_level", fifo_level, 3);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_ack", push_0a, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_valid", out_valid, 0);
    push_0r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    push(1, 0, 0, 1, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_level", fifo_level, 1);
    drain();
    chk_seq("post_rst", '{1});

`ifdef SENSE_RX_STATS_EN
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    push(1, 0, 0, 1, lat); push(1, 0, 0, 1, lat);
    push(0, 0, 0, 1, lat); push(1, 0, 0, 1, lat);
    push(0, 6, 0, 1, lat);
    drain();
    push(1, 0, 0, 1, lat);
    chk("stats_ones_lit", stat_ones, 4);
    chk("stats_total_lit", stat_total, 6);
    chk("stats_stall_lit", stat_stall, 3);
    push(1, 0, 4, 1, lat);
    chk("stats_clr_ones", stat_ones, 0);
    chk("stats_clr_total", stat_total, 0);
    chk("stats_clr_stall", stat_stall, 0);
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sense_sync_rx.md
Name: sense_sync_rx

Overview:
- Downstream consumer of the Balsa `sense` push channel.
- Terminates the 4-phase bundled-data push handshake (req/ack plus 1-bit data) into a single synchronous clock domain.
- Buffers sensed bits in a small first-word-fall-through FIFO.
- Presents the bits to synchronous logic as a valid/ready stream.
- Back-pressure from the synchronous side is applied by withholding the push acknowledge.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- SYNC_STAGES, 2: flip-flop stages on the incoming push_0r. Allowed range 2..3.
- CNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk, input, 1: sole clock. Rising edge.
- nreset, input, 1: asynchronous, active-low reset.
- push_0r, input, 1: push request from the async sense block. Not synchronised at source.
- push_0a, output, 1: push acknowledge. Registered.
- push_0d, input, 1: push data. Bundled with push_0r and stable while push_0r=1.
- out_valid, output, 1: FIFO head holds a bit.
- out_ready, input, 1: consumer accepts the head this cycle.
- out_data, output, 1: FIFO head bit.
- fifo_level, output, log2(DEPTH)+1: current occupancy.

Behaviour:
- Reset is asynchronous and active-low. While nreset=0:
  - push_0a=0, out_valid=0, out_data=0, fifo_level=0.
  - Sync chain cleared; FSM in IDLE.
- Reset release is synchronous to clk by the system.
- Request sync: push_0r passes through SYNC_STAGES flops to give req_s. Nothing else samples push_0r.
- Handshake FSM, three states; push_0a is a registered output of the FSM.
  - IDLE (ack=0): on req_s=1, go to CAPT.
  - CAPT (ack=0):
    - If FIFO not full (registered count < DEPTH): write push_0d into the FIFO, set ack=1, go to WAITLO.
    - If full: remain in CAPT with ack held 0. Retry every cycle.
  - WAITLO (ack=1): on req_s=0, set ack=0 and go to IDLE.
- Data sampling: push_0d is sampled directly in CAPT. It is valid by the bundled-data rule, because req_s lags push_0r by ≥2 cycles.
- Latency, push_0r rise to push_0a rise: SYNC_STAGES+2 clk edges minimum (4 with defaults), when not full.
- Latency, push_0r fall to push_0a fall: SYNC_STAGES+1 edges.
- At most one FIFO write per full 4-phase cycle; a write never happens on the return-to-zero phase.
- FIFO is first-word fall-through:
  - out_valid = (level ≠ 0); out_data = head entry.
  - A pop occurs when out_valid & out_ready.
- Simultaneous push and pop in one cycle:
  - Not full and not empty: both occur, level unchanged.
  - When full: the pop occurs and the write is deferred to the next cycle, because full is evaluated on the registered level.
  - When empty: only the write occurs; the new bit appears on out_data the following cycle.
- out_ready is ignored when out_valid=0.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH and never exceeds DEPTH.
- Reset mid-handshake: ack drops immediately and FIFO contents are discarded. The async sender shares the same initialisation, so no stale request survives. A request still high after release is treated as a new item.

Optional Feature:
- Macro SENSE_RX_STATS_EN.
- When defined, adds these ports:
  - stat_clr, input, 1: synchronous clear.
  - stat_ones, output, CNT_W: count of captured 1 bits.
  - stat_total, output, CNT_W: count of all captured bits.
  - stat_stall, output, CNT_W: cycles spent in CAPT with FIFO full.
- Counters saturate at all-ones and reset to 0.
- stat_clr has priority over an increment in the same cycle.
- When not defined, these ports and their logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset: hold nreset=0 with push_0r=1 → push_0a=0, out_valid=0, fifo_level=0. After release, the first handshake captures push_0d=1 and push_0a rises on the 4th edge after push_0r is seen.
- Stream of 8 handshakes with data 1,0,1,1,0,0,1,0 and out_ready=1 → out_data sequence is identical, no ack before data is written, fifo_level ≤ 1.
- Back-pressure: out_ready=0, 5 requests, DEPTH=4 → 4 acks, fifo_level=4, 5th push_0a stays 0. Raise out_ready for 1 cycle → the 5th write completes and push_0a rises within 2 cycles.
- Simultaneous pop and write at level=2 → level stays 2 and order is preserved.
- Assert nreset during WAITLO with level=3 → push_0a=0 and level=0 immediately (async). After release and push_0r low, the next handshake works normally.
- SENSE_RX_STATS_EN: 6 bits 1,1,0,1,0,1 with 3 full-stall cycles → stat_ones=4, stat_total=6, stat_stall=3. stat_clr together with a capture → all counters 0.
